mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_arb_pick.sv | 16 +
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state encoding, grant encoding and default widths for the memory-port arbiter.
package mem_arbiter_pkg;

    localparam int ARB_ADDR_W = 28;
    localparam int ARB_LINE_W = 128;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_I_BUSY = 2'd1,
        ARB_D_BUSY = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_grant_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational winner select between I- and D-cache requests.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  arb_grant_e last_grant,
    output logic       gnt_i,
    output logic       gnt_d
);

    // On conflict the cache not granted last wins.
    assign gnt_d = d_req & (~i_req | (last_grant == GNT_I));
    assign gnt_i = i_req & ~gnt_d;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 128-bit memory port between I-cache and D-cache, one transaction in flight.
// ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise the D-cache has fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
)(
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_e        state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              gnt_i, gnt_d;
    logic              idle;
    arb_grant_e        last_grant;

    assign idle = (state_q == ARB_IDLE);

`ifdef ARB_ROUND_ROBIN_EN
    arb_grant_e last_grant_q;

    always_ff @(posedge clk) begin
        if (proc_reset)
            last_grant_q <= GNT_D;
        else if (idle && (gnt_i || gnt_d))
            last_grant_q <= gnt_d ? GNT_D : GNT_I;
    end

    assign last_grant = last_grant_q;
`else
    // Pretending I was granted last makes the picker always favour D.
    assign last_grant = GNT_I;
`endif

    arb_pick u_pick (
        .i_req      (i_read),
        .d_req      (d_read | d_write),
        .last_grant (last_grant),
        .gnt_i      (gnt_i),
        .gnt_d      (gnt_d)
    );

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (idle) begin
            if (gnt_i || gnt_d) begin
                state_d     = gnt_d ? ARB_D_BUSY : ARB_I_BUSY;
                mem_addr_d  = gnt_d ? d_addr : i_addr;
                mem_wdata_d = gnt_d ? d_wdata : '0;
                // An illegal read+write request is served as a write.
                mem_write_d = gnt_d & d_write;
                mem_read_d  = gnt_i | (gnt_d & ~d_write);
            end
        end else if (mem_ready) begin
            state_d     = ARB_IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q     <= ARB_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign i_ready = (state_q == ARB_I_BUSY) & mem_ready;
    assign d_ready = (state_q == ARB_D_BUSY) & mem_ready;
    assign i_rdata = i_ready ? mem_rdata : '0;
    assign d_rdata = d_ready ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter, inputs driven on the falling edge.
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [127:0] WB_DATA  = 128'hDEAD0123_4567_89AB_CDEF_0011_2233_BEEF;
    localparam logic [127:0] RD_DATA  = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    localparam logic [127:0] RD_DATA2 = 128'h11112222_33334444_55556666_77778888;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         i_read, d_read, d_write, mem_ready;
    logic [27:0]  i_addr, d_addr;
    logic [127:0] d_wdata, mem_rdata;
    logic [127:0] i_rdata, d_rdata, mem_wdata;
    logic         i_ready, d_ready, mem_read, mem_write;
    logic [27:0]  mem_addr;

    int n_chk  = 0;
    int n_pass = 0;

    mem_arbiter dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_ready    (i_ready),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic exp_d;
        proc_reset = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick();
        tick();
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        proc_reset = 1'b0;
        tick();

        // I-cache fill alone, memory answers after three busy cycles
        i_read = 1'b1; i_addr = 28'h0000010;
        tick();
        chk("i_mem_read", mem_read, 1);
        chk("i_mem_write", mem_write, 0);
        chk("i_mem_addr", mem_addr, 28'h0000010);
        chk("i_no_early_ready", i_ready, 0);
        tick();
        tick();
        mem_ready = 1'b1; mem_rdata = RD_DATA;
        #1;
        chk("i_ready", i_ready, 1);
        chk("i_rdata", i_rdata, RD_DATA);
        chk("i_d_ready_quiet", d_ready, 0);
        chk("i_d_rdata_zero", d_rdata, 0);
        i_read = 1'b0;
        tick();
        mem_ready = 1'b0;
        chk("i_done_mem_read", mem_read, 0);

        // D-cache write-back, inputs changed mid-transaction must not leak through
        d_write = 1'b1; d_addr = 28'h0000020; d_wdata = WB_DATA;
        tick();
        chk("wb_mem_write", mem_write, 1);
        chk("wb_mem_read", mem_read, 0);
        chk("wb_mem_addr", mem_addr, 28'h0000020);
        chk("wb_mem_wdata", mem_wdata, WB_DATA);
        d_addr = 28'h0ABCDEF; d_wdata = RD_DATA2;
        tick();
        chk("wb_addr_stable", mem_addr, 28'h0000020);
        chk("wb_wdata_stable", mem_wdata, WB_DATA);
        mem_ready = 1'b1; mem_rdata = RD_DATA2;
        #1;
        chk("wb_d_ready", d_ready, 1);
        chk("wb_i_ready_quiet", i_ready, 0);
        chk("wb_i_rdata_zero", i_rdata, 0);
        d_write = 1'b0;
        tick();
        mem_ready = 1'b0;
        chk("wb_done_mem_write", mem_write, 0);

        // Conflict: round-robin alternates I,D,I; fixed priority serves D then I
        i_read = 1'b1; i_addr = 28'h0000030;
        d_read = 1'b1; d_addr = 28'h0000040;
        for (int t = 0; t < 3; t++) begin
            exp_d = RR ? (t == 1) : (t == 0);
            tick();
            chk($sformatf("cf%0d_mem_addr", t), mem_addr, exp_d ? 28'h0000040 : 28'h0000030);
            chk($sformatf("cf%0d_mem_read", t), mem_read, 1);
            mem_ready = 1'b1; mem_rdata = RD_DATA;
            #1;
            chk($sformatf("cf%0d_d_ready", t), d_ready, exp_d);
            chk($sformatf("cf%0d_i_ready", t), i_ready, !exp_d);
            if (!RR && exp_d) d_read = 1'b0;
            tick();
            mem_ready = 1'b0;
            chk($sformatf("cf%0d_idle_gap", t), mem_read, 0);
        end
        i_read = 1'b0; d_read = 1'b0;
        tick();

        // Illegal read+write is served as a write
        d_read = 1'b1; d_write = 1'b1; d_addr = 28'h0000044;
        tick();
        chk("rw_mem_write", mem_write, 1);
        chk("rw_mem_read", mem_read, 0);
        mem_ready = 1'b1;
        d_read = 1'b0; d_write = 1'b0;
        tick();
        mem_ready = 1'b0;

        // Request dropped while busy still completes
        d_read = 1'b1; d_addr = 28'h0000050;
        tick();
        chk("drop_mem_read", mem_read, 1);
        d_read = 1'b0;
        tick();
        chk("drop_mem_read_held", mem_read, 1);
        chk("drop_mem_addr", mem_addr, 28'h0000050);
        mem_ready = 1'b1; mem_rdata = RD_DATA2;
        #1;
        chk("drop_d_ready", d_ready, 1);
        chk("drop_d_rdata", d_rdata, RD_DATA2);
        tick();
        mem_ready = 1'b0;
        chk("drop_done", mem_read, 0);

        // Reset during I_BUSY abandons the transaction
        i_read = 1'b1; i_addr = 28'h0000060;
        tick();
        chk("rstmid_busy", mem_read, 1);
        proc_reset = 1'b1; i_read = 1'b0;
        tick();
        chk("rstmid_mem_read", mem_read, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        proc_reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rstmid_no_i_ready", i_ready, 0);
        tick();
        mem_ready = 1'b0;
        chk("rstmid_idle", mem_read, 0);

        // Stray mem_ready while idle
        mem_ready = 1'b1;
        #1;
        chk("stray_i_ready", i_ready, 0);
        chk("stray_d_ready", d_ready, 0);
        tick();
        chk("stray_mem_read", mem_read, 0);
        chk("stray_mem_write", mem_write, 0);
        mem_ready = 1'b0;
        d_read = 1'b1; d_addr = 28'h0000070;
        tick();
        chk("stray_then_grant", mem_read, 1);
        chk("stray_then_addr", mem_addr, 28'h0000070);
        d_read = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
